// File: rtl/rename_pkg.sv
// Shared constants, width helpers and register-index types for the rename stage.
package rename_pkg;

    localparam int unsigned DEF_NUM_AREG  = 32;
    localparam int unsigned DEF_NUM_PREG  = 128;
    localparam int unsigned DEF_WIDTH     = 2;
    localparam int unsigned DEF_RET_WIDTH = 2;

    function automatic int unsigned AREG_W(input int unsigned num_areg);
        return $clog2(num_areg);
    endfunction

    function automatic int unsigned PREG_W(input int unsigned num_preg);
        return $clog2(num_preg);
    endfunction

    typedef logic [AREG_W(DEF_NUM_AREG)-1:0] areg_t;
    typedef logic [PREG_W(DEF_NUM_PREG)-1:0] preg_t;

endpackage

// File: rtl/rename_freelist.sv
// Circular free list of physical registers: multi-pop from the head, multi-push at the tail.
module rename_freelist
    import rename_pkg::*;
#(
    parameter int unsigned NUM_AREG  = DEF_NUM_AREG,
    parameter int unsigned NUM_PREG  = DEF_NUM_PREG,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned RET_WIDTH = DEF_RET_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [$clog2(WIDTH+1)-1:0]             pop_count,
    output logic [WIDTH*PREG_W(NUM_PREG)-1:0]      peek,
    input  logic [RET_WIDTH-1:0]                   push_valid,
    input  logic [RET_WIDTH*PREG_W(NUM_PREG)-1:0]  push_preg,
    output logic [PREG_W(NUM_PREG):0]              count
);

    localparam int unsigned P     = PREG_W(NUM_PREG);
    localparam int unsigned DEPTH = NUM_PREG - NUM_AREG;
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [P-1:0]         mem [DEPTH];
    logic [IW-1:0]        head;
    logic [IW-1:0]        tail;
    logic [RET_WIDTH-1:0] push_we;
    logic [IW-1:0]        push_idx [RET_WIDTH];
    int unsigned          n_req;
    int unsigned          n_acc;
    int unsigned          space;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= DEPTH) sum = sum - DEPTH;
        return IW'(sum);
    endfunction

    always_comb begin
        peek = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            peek[k*P +: P] = mem[wrap_add(head, k)];
        end
    end

    // Pushes beyond the free space are dropped so the count saturates at DEPTH.
    always_comb begin
        n_req = 0;
        n_acc = 0;
        space = DEPTH - 32'(count) + 32'(pop_count);
        for (int unsigned k = 0; k < RET_WIDTH; k++) begin
            push_we[k]  = 1'b0;
            push_idx[k] = wrap_add(tail, n_acc);
            if (push_valid[k] && push_preg[k*P +: P] != '0) begin
                n_req = n_req + 1;
                if (n_acc < space) begin
                    push_we[k] = 1'b1;
                    n_acc      = n_acc + 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= P'(NUM_AREG + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= (P+1)'(DEPTH);
        end else begin
            assert (n_req == n_acc);
            for (int unsigned k = 0; k < RET_WIDTH; k++) begin
                if (push_we[k]) mem[push_idx[k]] <= push_preg[k*P +: P];
            end
            head  <= wrap_add(head, 32'(pop_count));
            tail  <= wrap_add(tail, n_acc);
            count <= count + (P+1)'(n_acc) - (P+1)'(pop_count);
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: speculative RAT with intra-group bypass, free-list allocation
// and a one-deep registered output stage.
module rename_stage
    import rename_pkg::*;
#(
    parameter int unsigned NUM_AREG  = DEF_NUM_AREG,
    parameter int unsigned NUM_PREG  = DEF_NUM_PREG,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned RET_WIDTH = DEF_RET_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH*AREG_W(NUM_AREG)-1:0]      rs1,
    input  logic [WIDTH*AREG_W(NUM_AREG)-1:0]      rs2,
    input  logic [WIDTH*AREG_W(NUM_AREG)-1:0]      rd,
    input  logic [WIDTH-1:0]                       regwrite,
    input  logic [WIDTH-1:0]                       use_rs2,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [WIDTH*PREG_W(NUM_PREG)-1:0]      prs1,
    output logic [WIDTH*PREG_W(NUM_PREG)-1:0]      prs2,
    output logic [WIDTH*PREG_W(NUM_PREG)-1:0]      prd,
    output logic [WIDTH*PREG_W(NUM_PREG)-1:0]      oldprd,
    input  logic [RET_WIDTH-1:0]                   free_valid,
    input  logic [RET_WIDTH*PREG_W(NUM_PREG)-1:0]  free_preg,
    output logic [PREG_W(NUM_PREG):0]              free_count
);

    localparam int unsigned A   = AREG_W(NUM_AREG);
    localparam int unsigned P   = PREG_W(NUM_PREG);
    localparam int unsigned PCW = $clog2(WIDTH+1);
    localparam logic [P:0]  MIN_FREE = (P+1)'(WIDTH);

    logic [P-1:0]       rat [NUM_AREG];
    logic               accept;
    logic [WIDTH-1:0]   alloc;
    logic [WIDTH*P-1:0] peek;
    logic [WIDTH*P-1:0] new_preg;
    logic [WIDTH*P-1:0] prs1_c, prs2_c, prd_c, oldprd_c;
    logic [PCW-1:0]     n_alloc;
    logic [PCW-1:0]     pop_count;
    logic [A-1:0]       s1, s2, d;
    logic [P-1:0]       v1, v2, vo;
    int unsigned        rank;

    assign in_ready  = (!out_valid || out_ready) && (free_count >= MIN_FREE);
    assign accept    = in_valid && in_ready;
    assign pop_count = accept ? n_alloc : '0;

    // Lanes take consecutive free-list entries; sources see the youngest earlier writer in the group.
    always_comb begin
        alloc    = '0;
        new_preg = '0;
        prs1_c   = '0;
        prs2_c   = '0;
        prd_c    = '0;
        oldprd_c = '0;
        rank     = 0;
        s1 = '0; s2 = '0; d = '0;
        v1 = '0; v2 = '0; vo = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            alloc[j] = regwrite[j] && (rd[j*A +: A] != '0);
            if (alloc[j]) begin
                new_preg[j*P +: P] = peek[rank*P +: P];
                rank = rank + 1;
            end
        end
        n_alloc = PCW'(rank);
        for (int unsigned j = 0; j < WIDTH; j++) begin
            s1 = rs1[j*A +: A];
            s2 = rs2[j*A +: A];
            d  = rd[j*A +: A];
            v1 = (s1 == '0) ? '0 : rat[s1];
            v2 = (s2 == '0) ? '0 : rat[s2];
            vo = rat[d];
            for (int unsigned i = 0; i < j; i++) begin
                if (alloc[i] && rd[i*A +: A] == s1) v1 = new_preg[i*P +: P];
                if (alloc[i] && rd[i*A +: A] == s2) v2 = new_preg[i*P +: P];
                if (alloc[i] && rd[i*A +: A] == d)  vo = new_preg[i*P +: P];
            end
            prs1_c[j*P +: P]   = v1;
            prs2_c[j*P +: P]   = use_rs2[j] ? v2 : '0;
            prd_c[j*P +: P]    = alloc[j] ? new_preg[j*P +: P] : '0;
            oldprd_c[j*P +: P] = alloc[j] ? vo : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_AREG; i++) begin
                rat[i] <= P'(i);
            end
        end else if (accept) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                if (alloc[j]) rat[rd[j*A +: A]] <= new_preg[j*P +: P];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            prs1      <= '0;
            prs2      <= '0;
            prd       <= '0;
            oldprd    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            prs1      <= prs1_c;
            prs2      <= prs2_c;
            prd       <= prd_c;
            oldprd    <= oldprd_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    rename_freelist #(
        .NUM_AREG  (NUM_AREG),
        .NUM_PREG  (NUM_PREG),
        .WIDTH     (WIDTH),
        .RET_WIDTH (RET_WIDTH)
    ) u_freelist (
        .clk        (clk),
        .reset      (reset),
        .pop_count  (pop_count),
        .peek       (peek),
        .push_valid (free_valid),
        .push_preg  (free_preg),
        .count      (free_count)
    );

endmodule

// File: tb/tb_rename_stage.sv
// Directed self-checking bench for rename_stage with default parameters.
module tb_rename_stage;
    import rename_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  rs1, rs2, rd;
    logic [1:0]  regwrite, use_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] prs1, prs2, prd, oldprd;
    logic [1:0]  free_valid;
    logic [13:0] free_preg;
    logic [7:0]  free_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rename_stage #(
        .NUM_AREG  (32),
        .NUM_PREG  (128),
        .WIDTH     (2),
        .RET_WIDTH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .regwrite   (regwrite),
        .use_rs2    (use_rs2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .prs1       (prs1),
        .prs2       (prs2),
        .prd        (prd),
        .oldprd     (oldprd),
        .free_valid (free_valid),
        .free_preg  (free_preg),
        .free_count (free_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic preg_t lane(input logic [13:0] v, input int k);
        return v[k*7 +: 7];
    endfunction

    task automatic set_lane(input int k, input int rd_v, input int rs1_v, input int rs2_v,
                            input logic rw, input logic u2);
        rd[k*5 +: 5]  = 5'(rd_v);
        rs1[k*5 +: 5] = 5'(rs1_v);
        rs2[k*5 +: 5] = 5'(rs2_v);
        regwrite[k]   = rw;
        use_rs2[k]    = u2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        rs1 = '0; rs2 = '0; rd = '0; regwrite = '0; use_rs2 = '0;
        free_valid = '0; free_preg = '0;
        do_reset();

        check("rst_out_valid", out_valid, 0);
        check("rst_free_count", free_count, 96);
        check("rst_in_ready", in_ready, 1);
        check("rst_prd", prd, 0);

        // Basic group with intra-group bypass on rs1.
        set_lane(0, 5, 1, 0, 1, 0);
        set_lane(1, 6, 5, 0, 1, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("g1_out_valid", out_valid, 1);
        check("g1_prd0", lane(prd, 0), 32);
        check("g1_prd1", lane(prd, 1), 33);
        check("g1_prs1_0", lane(prs1, 0), 1);
        check("g1_prs1_1", lane(prs1, 1), 32);
        check("g1_oldprd0", lane(oldprd, 0), 5);
        check("g1_oldprd1", lane(oldprd, 1), 6);
        check("g1_free_count", free_count, 94);
        step();
        check("g1_out_valid_clear", out_valid, 0);

        // Same rd in both lanes, then x0 destination and use_rs2 masking.
        do_reset();
        set_lane(0, 7, 0, 0, 1, 0);
        set_lane(1, 7, 7, 3, 1, 1);
        in_valid = 1'b1;
        step();
        check("waw_prd0", lane(prd, 0), 32);
        check("waw_prd1", lane(prd, 1), 33);
        check("waw_oldprd0", lane(oldprd, 0), 7);
        check("waw_oldprd1", lane(oldprd, 1), 32);
        check("waw_prs1_0", lane(prs1, 0), 0);
        check("waw_prs1_1", lane(prs1, 1), 32);
        check("waw_prs2_1", lane(prs2, 1), 3);
        set_lane(0, 0, 7, 9, 1, 0);
        set_lane(1, 4, 6, 7, 0, 1);
        step();
        in_valid = 1'b0;
        check("x0_prd0", lane(prd, 0), 0);
        check("x0_oldprd0", lane(oldprd, 0), 0);
        check("x0_prs1_0", lane(prs1, 0), 33);
        check("x0_prs2_0", lane(prs2, 0), 0);
        check("x0_prd1", lane(prd, 1), 0);
        check("x0_oldprd1", lane(oldprd, 1), 0);
        check("x0_prs1_1", lane(prs1, 1), 6);
        check("x0_prs2_1", lane(prs2, 1), 33);
        check("x0_free_count", free_count, 94);

        // Drain the free list, refill at the tail and check allocation order across the wrap.
        do_reset();
        set_lane(0, 1, 0, 0, 1, 0);
        set_lane(1, 2, 0, 0, 1, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 47; i++) step();
        check("drain_free_count2", free_count, 2);
        check("drain_in_ready2", in_ready, 1);
        check("drain_last_prd0", lane(prd, 0), 124);
        set_lane(1, 2, 0, 0, 0, 0);
        step();
        set_lane(1, 2, 0, 0, 1, 0);
        check("drain_single_prd0", lane(prd, 0), 126);
        check("drain_single_prd1", lane(prd, 1), 0);
        check("drain_free_count1", free_count, 1);
        check("drain_in_ready0", in_ready, 0);
        free_valid = 2'b11;
        free_preg  = {7'd41, 7'd40};
        step();
        free_valid = 2'b00;
        check("refill_free_count", free_count, 3);
        check("refill_in_ready", in_ready, 1);
        step();
        check("refill_prd0", lane(prd, 0), 127);
        check("refill_prd1", lane(prd, 1), 40);
        check("refill_free_count1", free_count, 1);
        free_valid = 2'b11;
        free_preg  = {7'd0, 7'd50};
        step();
        free_valid = 2'b00;
        check("p0_free_ignored", free_count, 2);
        step();
        in_valid = 1'b0;
        check("wrap_prd0", lane(prd, 0), 41);
        check("wrap_prd1", lane(prd, 1), 50);
        check("wrap_free_count", free_count, 0);

        // Back-pressure: outputs, RAT and free list frozen while stalled.
        do_reset();
        set_lane(0, 3, 2, 0, 1, 0);
        set_lane(1, 4, 3, 0, 1, 0);
        in_valid = 1'b1;
        step();
        out_ready = 1'b0;
        set_lane(0, 8, 3, 0, 1, 0);
        set_lane(1, 9, 4, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_out_valid", out_valid, 1);
            check("stall_prd0", lane(prd, 0), 32);
            check("stall_prs1_1", lane(prs1, 1), 32);
            check("stall_free_count", free_count, 94);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        check("resume_prd0", lane(prd, 0), 34);
        check("resume_prd1", lane(prd, 1), 35);
        check("resume_prs1_0", lane(prs1, 0), 32);
        check("resume_prs1_1", lane(prs1, 1), 33);
        check("resume_oldprd0", lane(oldprd, 0), 8);
        check("resume_free_count", free_count, 92);
        step();
        check("resume2_prd0", lane(prd, 0), 36);
        check("resume2_oldprd0", lane(oldprd, 0), 34);
        check("resume2_oldprd1", lane(oldprd, 1), 35);
        check("resume2_free_count", free_count, 90);

        // Reset asserted mid-stall with a pending group and a free request.
        out_ready = 1'b0;
        step();
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_prd1", lane(prd, 1), 37);
        reset      = 1'b1;
        free_valid = 2'b01;
        free_preg  = {7'd0, 7'd45};
        step();
        reset      = 1'b0;
        free_valid = 2'b00;
        in_valid   = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_free_count", free_count, 96);
        check("midrst_prd", prd, 0);
        check("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        set_lane(0, 9, 9, 8, 1, 1);
        set_lane(1, 3, 3, 0, 1, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_prs1_0", lane(prs1, 0), 9);
        check("post_rst_prs1_1", lane(prs1, 1), 3);
        check("post_rst_prs2_0", lane(prs2, 0), 8);
        check("post_rst_prd0", lane(prd, 0), 32);
        check("post_rst_prd1", lane(prd, 1), 33);
        check("post_rst_oldprd0", lane(oldprd, 0), 9);
        check("post_rst_oldprd1", lane(oldprd, 1), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 SHALL have parameter NUM_AREG, default 32, number of architectural registers.
REQ-002 SHALL have parameter NUM_PREG, default 128, number of physical registers (NUM_PREG > NUM_AREG).
REQ-003 SHALL have parameter WIDTH, default 2, rename lanes per group.
REQ-004 SHALL have parameter RET_WIDTH, default 2, free ports from RETIRE.
REQ-005 SHALL use one clock and a synchronous, active-high reset, named as follows.
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
REQ-006 SHALL have these ports (A = AREG_W = $clog2(NUM_AREG), P = PREG_W = $clog2(NUM_PREG); lane i occupies bits [i*A +: A] or [i*P +: P]):
- in_valid  in  1  decode group valid.
- in_ready  out  1  group accepted this cycle when in_valid and in_ready are both high.
- rs1, rs2, rd  in  WIDTH*A  architectural source and destination registers.
- regwrite  in  WIDTH  lane writes rd.
- use_rs2  in  WIDTH  lane reads rs2 (~ALUSrc | MemWrite).
- out_valid  out  1  renamed group valid.
- out_ready  in  1  downstream accepts.
- prs1, prs2, prd, oldprd  out  WIDTH*P  physical sources, new destination, previous mapping.
- free_valid  in  RET_WIDTH  retire frees a preg.
- free_preg  in  RET_WIDTH*P  preg to free.
- free_count  out  P+1  current free-list occupancy.

Function
REQ-007 SHALL hold a speculative RAT of NUM_AREG entries, each P bits wide; a lane "allocates" when regwrite=1 and rd!=0.
REQ-008 SHALL hold a circular free list of NUM_PREG-NUM_AREG entries with head, tail and count.
REQ-009 in_ready SHALL be (!out_valid | out_ready) & (free_count >= WIDTH), independent of in_valid and lane data.
REQ-010 On accept, SHALL register the results in the output stage with latency 1: out_valid is set in the next cycle.
REQ-011 out_valid and the output data SHALL hold stable while out_valid & !out_ready.
REQ-012 out_valid SHALL clear in the cycle after out_ready=1 with no new accept.
REQ-013 Allocating lanes SHALL pop consecutive free-list entries in lane order; lane 0 takes the head.
REQ-014 Source lookup SHALL use the RAT state before the group, with intra-group bypass:
- lane j rs1 or rs2 equal to the rd of the highest allocating lane i<j returns lane i's new preg.
REQ-015 oldprd SHALL be the RAT value, bypassed in the same way as REQ-014.
REQ-016 Non-allocating lanes SHALL give prd=0 and oldprd=0.
REQ-017 SHALL give prs2=0 when use_rs2=0.
REQ-018 rs1 or rs2 equal to 0 SHALL always map to p0; RAT[0] SHALL never change.
REQ-019 On accept, the RAT SHALL update in the same edge; when several lanes write the same rd, the highest lane wins.
REQ-020 Each free_valid lane with free_preg!=0 SHALL push to the tail in port order; frees of p0 SHALL be ignored.
REQ-021 Push and pop in the same cycle: count_next = count + pushes - pops.
- Preg values freed in cycle t SHALL be allocatable no earlier than t+1.
REQ-022 Head and tail SHALL wrap modulo NUM_PREG-NUM_AREG.
REQ-023 A push when full is illegal; the design SHALL carry a simulation assertion for it, and the count SHALL saturate.

Reset
REQ-024 On reset the RAT SHALL be RAT[i]=i.
REQ-025 On reset the free list SHALL hold NUM_AREG..NUM_PREG-1 in order, with head=0, tail=0 and count=NUM_PREG-NUM_AREG.
REQ-026 On reset out_valid SHALL be 0 and all data outputs SHALL be 0.
REQ-027 Reset SHALL override any accept or free in the same cycle, including mid-stall.

Structure
REQ-028 Package rename_pkg SHALL hold the default constants, the AREG_W and PREG_W functions, and the areg_t and preg_t typedefs.
REQ-029 The free list SHALL be the sub-module rename_freelist: multi-pop in WIDTH, multi-push in RET_WIDTH, exposing count.
REQ-030 RAT, bypass logic and output register SHALL live in rename_stage.

Verification
REQ-031 Reset, then group {rd=x5,rs1=x1 ; rd=x6,rs1=x5}, both regwrite -> prd=p32,p33; prs1=p1,p32; oldprd=p5,p6; free_count=94.
REQ-032 Two lanes both with rd=x7 -> prd=p32,p33; lane1 oldprd=p32; RAT[7]=p33 afterwards.
REQ-033 rd=x0 with regwrite=1, use_rs2=0 -> prd=0, prs2=0, free_count unchanged.
REQ-034 Drain to free_count=1 -> in_ready=0; free_valid=2'b11 with p40 and p41 -> in_ready=1 next cycle; next allocations return the old head before p40 and p41.
REQ-035 out_ready=0 for 3 cycles with in_valid held -> outputs stable, no RAT or free-list change; out_ready=1 -> exactly one new group accepted per cycle.
REQ-036 Assert reset mid-stall with a pending group -> next cycle out_valid=0, RAT identity, free_count=96.
